// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg -- shared definitions for the UART transmit controller slice.
//   tx_state_e         : transmit FSM state encoding
//   START_BIT/STOP_BIT : serial line levels for framing bits
//   DEFAULT_DATA_WIDTH : default payload width in bits
package uart_tx_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer -- loadable right-shift register plus data bit counter.
//   clk     : transmit clock
//   rst     : asynchronous active-low reset
//   load    : capture data_in, clear the bit counter
//   shift   : advance one bit (asserted for every cycle spent in DATA)
//   data_in : parallel payload
//   ser_bit : bit to be placed on the line at the coming edge
//   last    : the bit currently on the line is the final data bit
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ser_bit,
  output logic                  last
);

  localparam int unsigned           CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_adv;
  logic [CNT_W-1:0]      cnt;

  assign shreg_adv = shreg >> 1;
  assign last      = (cnt == CNT_LAST);

  // shreg[0] is the bit on the line while in DATA; the line register
  // loads one cycle ahead, so when advancing it needs the following bit.
  assign ser_bit = shift ? shreg_adv[0] : shreg[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= data_in;
      cnt   <= '0;
    end else if (shift) begin
      shreg <= shreg_adv;
      cnt   <= last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl -- UART transmit controller: start, LSB-first data,
// optional parity, stop; back-to-back frames when Data_Valid is present
// at the end of STOP.
//   clk        : transmit (baud) clock, one serial bit per cycle
//   rst        : asynchronous active-low reset
//   P_DATA     : parallel payload, sampled on frame acceptance
//   Data_Valid : send request (pulse or held)
//   PAR_EN     : insert parity bit, sampled on frame acceptance
//   par_bit    : upstream parity, captured on the START->DATA edge
//   TX_OUT     : registered serial line, idle high
//   busy       : registered, high while a frame is in progress
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  par_bit,
  output logic                  TX_OUT,
  output logic                  busy
);

  tx_state_e state;
  tx_state_e state_nxt;
  logic      par_en_q;
  logic      par_q;
  logic      load;
  logic      shift;
  logic      ser_bit;
  logic      last;
  logic      tx_nxt;
  logic      busy_nxt;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .shift  (shift),
    .data_in(P_DATA),
    .ser_bit(ser_bit),
    .last   (last)
  );

  assign shift = (state == ST_DATA);

  // State register, registered outputs and frame latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      TX_OUT   <= STOP_BIT;
      busy     <= 1'b0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      TX_OUT <= tx_nxt;
      busy   <= busy_nxt;
      if (load) begin
        par_en_q <= PAR_EN;
      end
      if (state == ST_START) begin
        par_q <= par_bit;
      end
    end
  end

  // Next-state logic; frames are accepted only from IDLE or at the end of STOP.
  always_comb begin
    state_nxt = ST_IDLE;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Data_Valid) begin
          state_nxt = ST_START;
          load      = 1'b1;
        end
      end
      ST_START:  state_nxt = ST_DATA;
      ST_DATA: begin
        if (!last)         state_nxt = ST_DATA;
        else if (par_en_q) state_nxt = ST_PARITY;
        else               state_nxt = ST_STOP;
      end
      ST_PARITY: state_nxt = ST_STOP;
      ST_STOP: begin
        if (Data_Valid) begin
          state_nxt = ST_START;
          load      = 1'b1;
        end
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output select is decoded from the next state so the registered line
  // changes on the same edge as the state it belongs to.
  always_comb begin
    tx_nxt   = STOP_BIT;
    busy_nxt = 1'b0;
    case (state_nxt)
      ST_START: begin
        tx_nxt   = START_BIT;
        busy_nxt = 1'b1;
      end
      ST_DATA: begin
        tx_nxt   = ser_bit;
        busy_nxt = 1'b1;
      end
      ST_PARITY: begin
        tx_nxt   = par_q;
        busy_nxt = 1'b1;
      end
      ST_STOP: begin
        tx_nxt   = STOP_BIT;
        busy_nxt = 1'b1;
      end
      default: begin
        tx_nxt   = STOP_BIT;
        busy_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl -- directed, table-driven bench for uart_tx_ctrl.
module tb_uart_tx_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] P_DATA;
  logic         Data_Valid;
  logic         PAR_EN;
  logic         par_bit;
  logic         TX_OUT;
  logic         busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // exp_tx bit i is the line level in cycle i of the frame (cycle 0 = start).
  typedef struct {
    logic [W-1:0] data;
    logic         par_en;
    logic         par_bit;
    int unsigned  len;
    logic [10:0]  exp_tx;
    logic         dv_pulse;
  } vec_t;

  vec_t vecs [6];

  uart_tx_ctrl #(
    .DATA_WIDTH(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .par_bit   (par_bit),
    .TX_OUT    (TX_OUT),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One frame from IDLE; inputs are perturbed after acceptance to show they
  // are not resampled mid-frame.
  task automatic run_frame(input vec_t v);
    @(negedge clk);
    P_DATA     = v.data;
    PAR_EN     = v.par_en;
    par_bit    = v.par_bit;
    Data_Valid = 1'b1;
    for (int unsigned i = 0; i < v.len; i++) begin
      @(negedge clk);
      check($sformatf("frame %02h tx[%0d]", v.data, i), TX_OUT, v.exp_tx[i]);
      check($sformatf("frame %02h busy[%0d]", v.data, i), busy, 1'b1);
      Data_Valid = 1'b0;
      if (i == 1) par_bit = ~v.par_bit;
      if (i == 2) begin
        P_DATA = ~v.data;
        PAR_EN = ~v.par_en;
      end
      if (v.dv_pulse && i == 4) begin
        Data_Valid = 1'b1;
        P_DATA     = '1;
      end
    end
    @(negedge clk);
    check($sformatf("frame %02h idle tx", v.data), TX_OUT, 1'b1);
    check($sformatf("frame %02h idle busy", v.data), busy, 1'b0);
  endtask

  initial begin
    logic [19:0] b2b_exp;

    rst        = 1'b1;
    Data_Valid = 1'b0;
    P_DATA     = '0;
    PAR_EN     = 1'b0;
    par_bit    = 1'b0;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 10, 11'b01101001010, 1'b0};
    vecs[1] = '{8'h81, 1'b1, 1'b0, 11, 11'b10100000010, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, 11, 11'b11001111000, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 10, 11'b01000000000, 1'b1};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 11, 11'b10111111110, 1'b0};
    vecs[5] = '{8'h5A, 1'b0, 1'b0, 10, 11'b01010110100, 1'b0};

    // Reset state, before and after clock edges under reset.
    #1 rst = 1'b0;
    #1;
    check("reset tx", TX_OUT, 1'b1);
    check("reset busy", busy, 1'b0);
    Data_Valid = 1'b1;
    repeat (3) @(negedge clk);
    check("reset held tx", TX_OUT, 1'b1);
    check("reset held busy", busy, 1'b0);
    Data_Valid = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post reset tx", TX_OUT, 1'b1);
      check("post reset busy", busy, 1'b0);
    end

    for (int unsigned k = 0; k < 6; k++) begin
      run_frame(vecs[k]);
    end

    // Back-to-back: Data_Valid held, new payload presented during STOP.
    b2b_exp = {10'b1000011110, 10'b1010101010};
    @(negedge clk);
    P_DATA     = 8'h55;
    PAR_EN     = 1'b0;
    Data_Valid = 1'b1;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("b2b tx[%0d]", i), TX_OUT, b2b_exp[i]);
      check($sformatf("b2b busy[%0d]", i), busy, 1'b1);
      if (i == 9)  P_DATA = 8'h0F;
      if (i == 10) Data_Valid = 1'b0;
    end
    @(negedge clk);
    check("b2b idle tx", TX_OUT, 1'b1);
    check("b2b idle busy", busy, 1'b0);

    // Reset during data bit 4 of an 0xA5 frame (bit 4 is 0 on the line).
    @(negedge clk);
    P_DATA     = 8'hA5;
    PAR_EN     = 1'b0;
    Data_Valid = 1'b1;
    @(negedge clk);
    Data_Valid = 1'b0;
    check("rstmid start tx", TX_OUT, 1'b0);
    repeat (5) @(negedge clk);
    check("rstmid bit4 tx", TX_OUT, 1'b0);
    check("rstmid bit4 busy", busy, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("rstmid async tx", TX_OUT, 1'b1);
    check("rstmid async busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rstmid idle tx", TX_OUT, 1'b1);
      check("rstmid idle busy", busy, 1'b0);
    end
    run_frame(vecs[1]);

    // Idle with payload toggling and no request.
    for (int unsigned i = 0; i < 50; i++) begin
      @(negedge clk);
      P_DATA = W'($urandom);
      check($sformatf("idle tx[%0d]", i), TX_OUT, 1'b1);
      check($sformatf("idle busy[%0d]", i), busy, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, 8, number of payload bits per frame.
REQ-002 Port: clk  input  1  transmit (baud-rate) clock; one serial bit per clk cycle.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: P_DATA  input  DATA_WIDTH  parallel payload, sampled only on frame acceptance.
REQ-005 Port: Data_Valid  input  1  request to send P_DATA; single-cycle or held.
REQ-006 Port: PAR_EN  input  1  1 = insert parity bit, sampled on frame acceptance.
REQ-007 Port: par_bit  input  1  registered parity from upstream parity calculator, valid from the cycle after Data_Valid.
REQ-008 Port: TX_OUT  output  1  registered serial line, idle high.
REQ-009 Port: busy  output  1  registered; high while a frame is in progress.
REQ-010 The block SHALL use the single clock clk; reset rst SHALL be asynchronous and active-low.

Function
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; all outputs registered, no combinational path from inputs to TX_OUT.
REQ-012 In IDLE with Data_Valid=1 at a rising edge: latch P_DATA and PAR_EN, go to START, busy=1 and TX_OUT=0 from that edge.
REQ-013 Data_Valid while not IDLE (except REQ-018) SHALL be ignored; latched data/PAR_EN unchanged.
REQ-014 START lasts exactly 1 cycle; on START->DATA edge the block SHALL latch par_bit internally (upstream value may change afterwards).
REQ-015 DATA SHALL drive bits LSB first, one per cycle, DATA_WIDTH cycles, via bit counter 0..DATA_WIDTH-1; counter SHALL clear on leaving DATA.
REQ-016 After last data bit: PAR_EN latched 1 -> PARITY (1 cycle, TX_OUT = latched parity); else directly STOP.
REQ-017 STOP lasts 1 cycle, TX_OUT=1; frame length = DATA_WIDTH+2 cycles (+1 with parity): 10/11 for default.
REQ-018 Data_Valid=1 at the edge ending STOP SHALL start a new frame (STOP->START, busy stays 1, no idle gap); else STOP->IDLE, busy=0, TX_OUT=1.
REQ-019 In IDLE TX_OUT SHALL be 1 and busy 0; P_DATA changes in IDLE SHALL have no effect.
REQ-020 Unreachable state encodings SHALL recover to IDLE next edge with TX_OUT=1.

Reset
REQ-021 While rst=0: state IDLE, TX_OUT=1, busy=0, bit counter 0, data/parity/PAR_EN latches 0.
REQ-022 Reset asserted mid-frame SHALL force TX_OUT=1 and busy=0 immediately (asynchronously), abandoning the frame.
REQ-023 First frame after deassertion SHALL require a fresh Data_Valid; no frame replay.

Structure
REQ-024 Shared package uart_tx_pkg SHALL hold the state enumeration, START_BIT=0, STOP_BIT=1 and default DATA_WIDTH.
REQ-025 One sub-module uart_tx_serializer SHALL hold the load-able shift register and bit counter (ports: clk, rst, load, shift, data_in, ser_bit, last); the FSM stays in uart_tx_ctrl.
REQ-026 Select logic for TX_OUT (start/data/parity/stop/idle) SHALL reside in uart_tx_ctrl and be registered.

Verification
REQ-027 P_DATA=0xA5, PAR_EN=0, 1-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 over 10 cycles, busy high exactly 10 cycles.
REQ-028 P_DATA=0x81, PAR_EN=1, par_bit=0 (even) -> 0,1,0,0,0,0,0,0,1,0,1 over 11 cycles; par_bit toggled after START does not change the parity bit.
REQ-029 Data_Valid held high with 0x55 then 0x0F presented in the STOP cycle -> two back-to-back frames, no idle cycle, busy continuously high for 20 cycles, second frame carries 0x0F.
REQ-030 Data_Valid pulsed with P_DATA=0xFF during DATA of a 0x00 frame -> frame unchanged (all-zero data), pulse dropped, idle after stop.
REQ-031 rst pulled low during data bit 4 -> TX_OUT=1, busy=0 within same cycle; after release, line idles until next Data_Valid.
REQ-032 Idle with P_DATA toggling, Data_Valid=0 for 50 cycles -> TX_OUT constantly 1, busy constantly 0.
